// File: rtl/sram_mem_responder.sv
// Data-memory responder for the MEM stage. Each 32-bit load or store becomes
// two 16-bit accesses on an external asynchronous SRAM: the low halfword
// first, then the high halfword. An optional WAIT stretch follows, and then
// a single DONE cycle. The core freezes the whole pipeline while `ready` is
// low, so the request inputs stay stable until DONE.
module sram_mem_responder #(
    parameter int unsigned BASE_ADDR   = 1024, // byte address of SRAM word 0
    parameter int unsigned WAIT_CYCLES = 5,    // freeze cycles per access, >= 3
    parameter int unsigned SRAM_ADDR_W = 18    // SRAM halfword address width, <= 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    // A 32-bit word is two halfwords, so the word index is one bit narrower
    // than the SRAM halfword address.
    localparam int unsigned WORD_W = SRAM_ADDR_W - 1;
    localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES + 1);

    // LO and HI take two of the freeze cycles. The accept cycle in IDLE takes
    // one more. WAIT covers whatever is left.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Request captured at acceptance. The requester holds its inputs, but
    // the latch keeps the SRAM side independent of what the ALU drives later.
    logic [WORD_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic              is_write_q;

    logic              req;
    logic [31:0]       offset;
    logic [WORD_W-1:0] word_in;
    logic              unused_offset_bits;

    assign req = wr_en | rd_en;

    // Addresses below BASE_ADDR wrap modulo 2^32 and are not trapped. The
    // byte lane bits [1:0] are ignored, so every access is word aligned.
    assign offset             = address - 32'(BASE_ADDR);
    assign word_in            = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    // The chip and both byte lanes stay enabled. Each access is a full halfword.
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    // ready is high with no request in IDLE, and in DONE. A request arriving
    // in IDLE drops ready in the same cycle, so the pipeline freezes at once.
    assign ready = ((state == S_IDLE) && !req) || (state == S_DONE);

    // State register and wait counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values no matter how the blocks are ordered.
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture word address, store data and operation when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else if ((state == S_IDLE) && req) begin
            word_q     <= word_in;
            wdata_q    <= write_data;
            is_write_q <= wr_en;   // a write wins when both enables are high
        end
    end

    // Load each half of read_data at the edge that ends its SRAM read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!is_write_q) begin
            if (state == S_LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == S_HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path can leave it unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                state_nxt = S_HI;
            end
            S_HI: begin
                cnt_nxt = CNT_INIT;
                if (CNT_INIT == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A request present now waits for the next IDLE cycle.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM pin control. The pins are active only in LO and HI, and the
    // operation selects either the write strobe or the read strobe.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state)
            S_LO: begin
                sram_addr = {word_q, 1'b0};
                if (is_write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            S_HI: begin
                sram_addr = {word_q, 1'b1};
                if (is_write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // The SRAM must never see both strobes low together: that would be
    // bus contention on the shared data lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (sram_we_n || sram_oe_n);
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed testbench for sram_mem_responder. The main instance uses the
// default parameters and has a small halfword SRAM model. A second instance
// with WAIT_CYCLES=3 checks the shortest timing with back-to-back reads.
module tb_sram_mem_responder;

    logic        clk;
    logic        rst;

    // Default-parameter instance.
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    // WAIT_CYCLES=3 instance.
    logic        wr_en3;
    logic        rd_en3;
    logic [31:0] address3;
    logic [31:0] write_data3;
    logic [31:0] read_data3;
    logic        ready3;
    logic [17:0] sram_addr3;
    logic [15:0] sram_dq_out3;
    logic [15:0] sram_dq_in3;
    logic        sram_dq_oe3;
    logic        sram_we_n3;
    logic        sram_oe_n3;
    logic        sram_ce_n3;
    logic        sram_ub_n3;
    logic        sram_lb_n3;

    int checks;
    int errors;

    // Values captured by run_req for one full access.
    logic [5:0]  rdy_seq;
    logic [17:0] lo_addr, hi_addr;
    logic [15:0] lo_dq, hi_dq;
    logic        lo_we, hi_we, lo_oe, hi_oe, lo_dqoe, hi_dqoe;
    int          idle_viol;
    logic [31:0] rd_done;
    int          both_low;

    // Halfword SRAM model. The low six address bits select the entry.
    logic [15:0] mem [0:63];

    sram_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    sram_mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en3),
        .rd_en      (rd_en3),
        .address    (address3),
        .write_data (write_data3),
        .read_data  (read_data3),
        .ready      (ready3),
        .sram_addr  (sram_addr3),
        .sram_dq_out(sram_dq_out3),
        .sram_dq_in (sram_dq_in3),
        .sram_dq_oe (sram_dq_oe3),
        .sram_we_n  (sram_we_n3),
        .sram_oe_n  (sram_oe_n3),
        .sram_ce_n  (sram_ce_n3),
        .sram_ub_n  (sram_ub_n3),
        .sram_lb_n  (sram_lb_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: a strobed write is captured at the clock edge, and a read returns data while oe_n is low.
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in  = !sram_oe_n ? mem[sram_addr[5:0]] : 16'h0000;
    // The second instance reads a pattern derived from the address: 0x1000 + halfword address.
    assign sram_dq_in3 = !sram_oe_n3 ? (16'h1000 + sram_addr3[15:0]) : 16'h0000;

    // Contention monitor for the main instance.
    always @(negedge clk) begin
        if (!sram_we_n && !sram_oe_n) both_low <= both_low + 1;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

    // Hold one request for WAIT_CYCLES+1 cycles (accept through DONE) on the
    // main instance and record what the pins show. Called just after a rising
    // edge, with the DUT in IDLE. It returns just after the DONE edge with the
    // enables dropped.
    task automatic run_req(input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d);
        wr_en = w; rd_en = r; address = a; write_data = d;
        idle_viol = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rdy_seq[k] = ready;
            if (k == 1) begin
                lo_addr = sram_addr; lo_dq = sram_dq_out; lo_we = sram_we_n;
                lo_oe = sram_oe_n; lo_dqoe = sram_dq_oe;
            end else if (k == 2) begin
                hi_addr = sram_addr; hi_dq = sram_dq_out; hi_we = sram_we_n;
                hi_oe = sram_oe_n; hi_dqoe = sram_dq_oe;
            end else if (!sram_we_n || !sram_oe_n || sram_dq_oe || (sram_dq_out != 16'h0)) begin
                idle_viol++;
            end
            if (k == 5) rd_done = read_data;
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin errors++;
            $display("FAIL reset_strobes: got we_n/oe_n/dq_oe=%b expected 110", {sram_we_n, sram_oe_n, sram_dq_oe}); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 00000000", read_data); end
        checks++; if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin errors++;
            $display("FAIL tied_enables: got ce/ub/lb=%b expected 000", {sram_ce_n, sram_ub_n, sram_lb_n}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write;
        run_req(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
        checks++; if (rdy_seq !== 6'b100000) begin errors++; $display("FAIL write_ready_seq: got %b expected 100000", rdy_seq); end
        checks++; if (lo_addr !== 18'd0 || lo_dq !== 16'hBEEF || lo_we !== 1'b0 || lo_dqoe !== 1'b1 || lo_oe !== 1'b1) begin errors++;
            $display("FAIL write_lo: got addr=%h dq=%h we_n=%b dq_oe=%b oe_n=%b expected 0 beef 0 1 1", lo_addr, lo_dq, lo_we, lo_dqoe, lo_oe); end
        checks++; if (hi_addr !== 18'd1 || hi_dq !== 16'hDEAD || hi_we !== 1'b0 || hi_dqoe !== 1'b1) begin errors++;
            $display("FAIL write_hi: got addr=%h dq=%h we_n=%b dq_oe=%b expected 1 dead 0 1", hi_addr, hi_dq, hi_we, hi_dqoe); end
        checks++; if (idle_viol !== 0) begin errors++; $display("FAIL write_idle_pins: got %0d non-idle cycles expected 0", idle_viol); end
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin errors++;
            $display("FAIL write_sram_content: got %h %h expected beef dead", mem[0], mem[1]); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL write_keeps_read_data: got %h expected 00000000", read_data); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL write_idle_ready: got %b expected 1", ready); end
        @(posedge clk); #1;
    endtask

    // Halfwords 0 and 1 already hold 0xBEEF and 0xDEAD from the write above.
    task automatic test_read_back;
        run_req(1'b0, 1'b1, 32'd1024, 32'h0);
        checks++; if (rdy_seq !== 6'b100000) begin errors++; $display("FAIL read_ready_seq: got %b expected 100000", rdy_seq); end
        checks++; if (rd_done !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data_done: got %h expected deadbeef", rd_done); end
        checks++; if (lo_we !== 1'b1 || hi_we !== 1'b1 || lo_dqoe !== 1'b0 || idle_viol !== 0) begin errors++;
            $display("FAIL read_no_write: got we_n lo/hi=%b%b dq_oe=%b idle_viol=%0d expected 11 0 0", lo_we, hi_we, lo_dqoe, idle_viol); end
        checks++; if (lo_oe !== 1'b0 || hi_oe !== 1'b0 || lo_addr !== 18'd0 || hi_addr !== 18'd1) begin errors++;
            $display("FAIL read_strobes: got oe_n lo/hi=%b%b addr=%h/%h expected 00 0/1", lo_oe, hi_oe, lo_addr, hi_addr); end
    endtask

    task automatic test_both_enables;
        run_req(1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A);
        checks++; if (lo_addr !== 18'd2 || hi_addr !== 18'd3 || lo_we !== 1'b0 || lo_oe !== 1'b1 || hi_oe !== 1'b1) begin errors++;
            $display("FAIL both_en_pins: got addr=%h/%h we_n=%b oe_n=%b%b expected 2/3 0 11", lo_addr, hi_addr, lo_we, lo_oe, hi_oe); end
        checks++; if (mem[2] !== 16'h5A5A || mem[3] !== 16'hA5A5) begin errors++;
            $display("FAIL both_en_written: got %h %h expected 5a5a a5a5", mem[2], mem[3]); end
        checks++; if (rd_done !== 32'hDEAD_BEEF) begin errors++; $display("FAIL both_en_read_data: got %h expected deadbeef", rd_done); end
    endtask

    task automatic test_address_map;
        run_req(1'b1, 1'b0, 32'd1034, 32'h1234_5678);
        checks++; if (lo_addr !== 18'd4 || hi_addr !== 18'd5) begin errors++;
            $display("FAIL map_write_addr: got %h/%h expected 4/5", lo_addr, hi_addr); end
        checks++; if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin errors++;
            $display("FAIL map_write_content: got %h %h expected 5678 1234", mem[4], mem[5]); end
        run_req(1'b0, 1'b1, 32'd1033, 32'h0);
        checks++; if (lo_addr !== 18'd4 || hi_addr !== 18'd5) begin errors++;
            $display("FAIL map_read_addr: got %h/%h expected 4/5", lo_addr, hi_addr); end
        checks++; if (rd_done !== 32'h1234_5678) begin errors++; $display("FAIL map_read_data: got %h expected 12345678", rd_done); end
    endtask

    task automatic test_reset_mid_op;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h1111_2222;
        @(posedge clk); #1;                  // cycle T+1: LO
        rst = 1'b1;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rst_mid_in_lo: got we_n=%b expected 0", sram_we_n); end
        @(posedge clk); #1;                  // reset edge taken
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++;
            $display("FAIL rst_mid_idle_pins: got we_n=%b dq_oe=%b expected 1 0", sram_we_n, sram_dq_oe); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_mid_read_data: got %h expected 00000000", read_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_held: got %b expected 0", ready); end
        @(posedge clk); #1;                  // restarted request now in LO
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd8 || sram_dq_out !== 16'h2222) begin errors++;
            $display("FAIL rst_mid_restart: got we_n=%b addr=%h dq=%h expected 0 8 2222", sram_we_n, sram_addr, sram_dq_out); end
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_done: got ready=%b expected 1", ready); end
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++; if (mem[8] !== 16'h2222 || mem[9] !== 16'h1111) begin errors++;
            $display("FAIL rst_mid_content: got %h %h expected 2222 1111", mem[8], mem[9]); end
    endtask

    // Byte address 0 lies below BASE_ADDR: the offset wraps to 0xFFFFFC00,
    // whose bits [18:2] give word 0x1FF00.
    task automatic test_wrap;
        run_req(1'b1, 1'b0, 32'd0, 32'h0BAD_F00D);
        checks++; if (lo_addr !== 18'h3FE00 || hi_addr !== 18'h3FE01) begin errors++;
            $display("FAIL wrap_addr: got %h/%h expected 3fe00/3fe01", lo_addr, hi_addr); end
        checks++; if (rdy_seq !== 6'b100000) begin errors++; $display("FAIL wrap_ready_seq: got %b expected 100000", rdy_seq); end
    endtask

    // Two back-to-back reads on the WAIT_CYCLES=3 instance. rd_en stays high
    // the whole time, and the address moves on after the first DONE edge.
    task automatic test_back_to_back;
        logic [7:0]  rdy3;
        logic [31:0] rd3_a, rd3_b;
        logic [17:0] addr3_lo;
        int          we3_low;
        we3_low = 0;
        rd_en3 = 1'b1; address3 = 32'd1032;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rdy3[k] = ready3;
            if (!sram_we_n3) we3_low++;
            if (k == 1) addr3_lo = sram_addr3;
            if (k == 3) begin
                rd3_a = read_data3;
                checks++; if ({sram_dq_oe3, sram_dq_out3, sram_oe_n3, sram_ce_n3, sram_ub_n3, sram_lb_n3} !== {1'b0, 16'h0, 1'b1, 3'b000}) begin errors++;
                    $display("FAIL b2b_done_pins: got dq_oe=%b dq=%h oe_n=%b ce/ub/lb=%b expected 0 0000 1 000",
                             sram_dq_oe3, sram_dq_out3, sram_oe_n3, {sram_ce_n3, sram_ub_n3, sram_lb_n3}); end
            end
            if (k == 7) rd3_b = read_data3;
            @(posedge clk); #1;
            if (k == 3) address3 = 32'd1036;
        end
        rd_en3 = 1'b0;
        checks++; if (rdy3 !== 8'b1000_1000) begin errors++; $display("FAIL b2b_ready_seq: got %b expected 10001000", rdy3); end
        checks++; if (addr3_lo !== 18'd4) begin errors++; $display("FAIL b2b_first_addr: got %h expected 4", addr3_lo); end
        checks++; if (rd3_a !== 32'h1005_1004) begin errors++; $display("FAIL b2b_first_data: got %h expected 10051004", rd3_a); end
        checks++; if (rd3_b !== 32'h1007_1006) begin errors++; $display("FAIL b2b_second_data: got %h expected 10071006", rd3_b); end
        checks++; if (we3_low !== 0) begin errors++; $display("FAIL b2b_no_write: got %0d write strobes expected 0", we3_low); end
        @(negedge clk);
        checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", ready3); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; errors = 0; both_low = 0;
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        wr_en3 = 1'b0; rd_en3 = 1'b0; address3 = '0; write_data3 = '0;
        rdy_seq = '0; rd_done = '0; idle_viol = 0;
        lo_addr = '0; hi_addr = '0; lo_dq = '0; hi_dq = '0;
        lo_we = 1'b1; hi_we = 1'b1; lo_oe = 1'b1; hi_oe = 1'b1; lo_dqoe = 1'b0; hi_dqoe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_write;
        test_read_back;
        test_both_enables;
        test_address_map;
        test_reset_mid_op;
        test_wrap;
        test_back_to_back;
        checks++; if (both_low !== 0) begin errors++; $display("FAIL strobe_contention: got %0d cycles expected 0", both_low); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
